// File: rtl/board_io_display.sv
// Board front-end: synchronised and debounced switches plus run key, a sequential
// double-dabble binary-to-BCD converter, and seven-segment drive with blanking and overflow.
`timescale 1ns/1ps
module board_io_display #(
    parameter int SW_W        = 8,
    parameter int DATA_W      = 10,
    parameter int DIGITS      = 3,
    parameter int DEB_CYCLES  = 16,
    parameter int LZB         = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_W-1:0]       sw_raw,
    input  logic                  run_raw,
    input  logic [DATA_W-1:0]     value,
    input  logic                  value_valid,
    output logic [SW_W-1:0]       sw_db,
    output logic                  run_db,
    output logic                  run_pulse,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex,
    output logic [SW_W+1:0]       led
);
    localparam int NIN = SW_W + 1;
    localparam int CW  = $clog2(DEB_CYCLES);
    localparam int BW  = 4 * DIGITS;
    localparam int NW  = $clog2(DATA_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    // Segment pattern, active-high, bit order {g,f,e,d,c,b,a}; codes 10..15 are blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Input path: bit 0 is the run key, bits NIN-1:1 the switches.
    logic [NIN-1:0] in_raw, sync1_reg, sync2_reg, db_vec;
    logic           run_q_reg;

    assign in_raw = {sw_raw, run_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            run_q_reg <= 1'b0;
        end else begin
            sync1_reg <= in_raw;
            sync2_reg <= sync1_reg;
            run_q_reg <= db_vec[0];
        end
    end

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_deb
            logic [CW-1:0] cnt_reg;
            logic          db_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else if (sync2_reg[gi] == db_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                    db_reg  <= sync2_reg[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
            assign db_vec[gi] = db_reg;
        end
    endgenerate

    assign run_db    = db_vec[0];
    assign sw_db     = db_vec[NIN-1:1];
    assign run_pulse = db_vec[0] & ~run_q_reg;

    // Converter
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   shreg_reg, shreg_next;
    logic [BW-1:0]       bcd_reg, bcd_next, bcd_adj;
    logic [NW-1:0]       bitcnt_reg, bitcnt_next;
    logic                ovf_n_reg, ovf_n_next;
    logic [BW-1:0]       disp_reg, disp_next;
    logic                ovf_reg, ovf_next;
    logic                done_reg, done_next;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        bcd_next    = bcd_reg;
        bitcnt_next = bitcnt_reg;
        ovf_n_next  = ovf_n_reg;
        disp_next   = disp_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (value_valid) begin
                    shreg_next  = value;
                    ovf_n_next  = (64'(value) >= LIMIT);
                    bcd_next    = '0;
                    bitcnt_next = NW'(DATA_W);
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                // Carry out of the top digit falls off: result is value mod 10**DIGITS.
                bcd_next    = BW'({bcd_adj, shreg_reg[DATA_W-1]});
                shreg_next  = shreg_reg << 1;
                bitcnt_next = bitcnt_reg - NW'(1);
                if (bitcnt_reg == NW'(1)) state_next = DONE;
            end
            DONE: begin
                disp_next  = bcd_reg;
                ovf_next   = ovf_n_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            shreg_reg  <= '0;
            bcd_reg    <= '0;
            bitcnt_reg <= '0;
            ovf_n_reg  <= 1'b0;
            disp_reg   <= '0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shreg_reg  <= shreg_next;
            bcd_reg    <= bcd_next;
            bitcnt_reg <= bitcnt_next;
            ovf_n_reg  <= ovf_n_next;
            disp_reg   <= disp_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign ovf  = ovf_reg;
    assign led  = {sw_db, run_db, busy};

    // nz[i] is set when digit i or any higher digit is non-zero.
    logic [DIGITS:0] nz;
    assign nz[DIGITS] = 1'b0;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
            localparam bit CAN_BLANK = (LZB != 0) && (gi > 0);
            logic [6:0] pat;
            assign nz[gi] = nz[gi+1] | (disp_reg[4*gi +: 4] != 4'd0);
            always_comb begin
                pat = seg7(disp_reg[4*gi +: 4]);
                if (ovf_reg)
                    pat = 7'h40;
                else if (CAN_BLANK && !nz[gi])
                    pat = 7'h00;
            end
            assign hex[7*gi +: 7] = (SEG_ACT_LOW != 0) ? ~pat : pat;
        end
    endgenerate
endmodule
